chan_packet_ctrl: RTL and testbench

Sequencer for the channel packetizer, in the user_clk domain downstream of the chan_packet software register.
- Decodes the 32-bit control word written by the PPC into arm, mode, channel-select and length fields.
- Waits for a frame sync, then selects samples of one channel from the channelizer stream and emits framed packets (sof/eof) toward the packet FIFO.
- Keeps a packet count and a sticky overflow status for readback.

---
 rtl/chan_packet_if.sv | 41 ++++
 rtl/chan_packet_ctrl.sv | 178 +++++++++++++++++
 tb/tb_chan_packet_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chan_packet_if.sv
// Channel packetizer bus bundle: control word, channelizer input stream,
// packet output stream and status readback.
//
// Handshake: din_valid qualifies din_data/din_chan for exactly the cycle it
// is high; there is no input back-pressure. dout_valid is a one-cycle pulse
// per emitted word. dout_ready is sampled in the cycle a matched sample (or
// the header) is taken: if it is low the matched sample is dropped and
// overflow is set, so an emitted word is never held or repeated.
interface chan_packet_if #(
    parameter int DATA_W = 32,
    parameter int CHAN_W = 8
);
    logic [31:0]       cfg_reg;
    logic              sync_in;
    logic [DATA_W-1:0] din_data;
    logic [CHAN_W-1:0] din_chan;
    logic              din_valid;
    logic              dout_ready;
    logic [DATA_W-1:0] dout_data;
    logic              dout_valid;
    logic              dout_sof;
    logic              dout_eof;
    logic              busy;
    logic [15:0]       pkt_count;
    logic              overflow;
    logic [2:0]        dbg_state;

    // Driver side: software register, channelizer and downstream FIFO.
    modport master (
        output cfg_reg, sync_in, din_data, din_chan, din_valid, dout_ready,
        input  dout_data, dout_valid, dout_sof, dout_eof, busy, pkt_count,
               overflow, dbg_state
    );

    // Sequencer side.
    modport slave (
        input  cfg_reg, sync_in, din_data, din_chan, din_valid, dout_ready,
        output dout_data, dout_valid, dout_sof, dout_eof, busy, pkt_count,
               overflow, dbg_state
    );
endinterface

// File: rtl/chan_packet_ctrl.sv
// Channel packetizer sequencer.
// Decodes the control word ([31] arm, [30] single_shot, [23:16] chan_sel,
// [11:0] pkt_len), waits for a frame sync, then forwards samples of the
// selected channel as sof/eof framed packets with an idle gap in between.
// Optional macro CHAN_PACKET_HEADER_EN inserts a header word
// {chan_sel, 8'h00, pkt_count} in front of each packet.
module chan_packet_ctrl #(
    parameter int DATA_W     = 32,
    parameter int CHAN_W     = 8,
    parameter int LEN_W      = 12,
    parameter int GAP_CYCLES = 4
) (
    input  logic          user_clk,
    input  logic          user_rst,
    chan_packet_if.slave  bus
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_SYNC = 3'd1,
        HDR       = 3'd2,
        SEND      = 3'd3,
        GAP       = 3'd4
    } state_t;

    state_t            state_q;
    logic              arm_q;
    logic [CHAN_W-1:0] chan_q;
    logic [LEN_W-1:0]  len_q;
    logic              single_q;
    logic [LEN_W-1:0]  wcnt_q;
    logic [GAP_W-1:0]  gcnt_q;
    logic [DATA_W-1:0] dout_data_q;
    logic              dout_valid_q;
    logic              dout_sof_q;
    logic              dout_eof_q;
    logic [15:0]       pkt_count_q;
    logic              overflow_q;

    // Control word fields, decoded straight off the register.
    logic              cfg_arm;
    logic              cfg_single;
    logic [CHAN_W-1:0] cfg_chan;
    logic [LEN_W-1:0]  cfg_len;
    logic              arm_rise;
    logic              match;
    logic              last_word;
    logic              unused_cfg;

    assign cfg_arm    = bus.cfg_reg[31];
    assign cfg_single = bus.cfg_reg[30];
    assign cfg_chan   = bus.cfg_reg[16 +: CHAN_W];
    assign cfg_len    = bus.cfg_reg[LEN_W-1:0];
    assign unused_cfg = ^bus.cfg_reg;

    assign arm_rise  = cfg_arm && !arm_q;
    assign match     = bus.din_valid && (bus.din_chan == chan_q);
    assign last_word = (wcnt_q == (len_q - 1'b1));

    // Sequencer: arm detection, shadow config, framing, counters and status.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_q      <= IDLE;
            arm_q        <= 1'b0;
            chan_q       <= '0;
            len_q        <= '0;
            single_q     <= 1'b0;
            wcnt_q       <= '0;
            gcnt_q       <= '0;
            dout_data_q  <= '0;
            dout_valid_q <= 1'b0;
            dout_sof_q   <= 1'b0;
            dout_eof_q   <= 1'b0;
            pkt_count_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            arm_q        <= cfg_arm;
            dout_valid_q <= 1'b0;
            dout_sof_q   <= 1'b0;
            dout_eof_q   <= 1'b0;

            // A fresh arm edge starts a new status epoch; a drop in the same
            // cycle below still wins.
            if (arm_rise) begin
                overflow_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (arm_rise && (cfg_len != '0)) begin
                        chan_q   <= cfg_chan;
                        len_q    <= cfg_len;
                        single_q <= cfg_single;
                        state_q  <= WAIT_SYNC;
                    end
                end

                WAIT_SYNC: begin
                    if (!cfg_arm) begin
                        state_q <= IDLE;
                    end else if (bus.sync_in) begin
                        wcnt_q  <= '0;
`ifdef CHAN_PACKET_HEADER_EN
                        state_q <= HDR;
`else
                        state_q <= SEND;
`endif
                    end
                end

`ifdef CHAN_PACKET_HEADER_EN
                HDR: begin
                    // The header slot owns the output register this cycle,
                    // so a matched sample has nowhere to go.
                    if (match) begin
                        overflow_q <= 1'b1;
                    end
                    if (bus.dout_ready) begin
                        dout_data_q  <= DATA_W'({8'(chan_q), 8'h00, pkt_count_q});
                        dout_valid_q <= 1'b1;
                        dout_sof_q   <= 1'b1;
                        state_q      <= SEND;
                    end
                end
`endif

                SEND: begin
                    if (match) begin
                        if (!bus.dout_ready) begin
                            overflow_q <= 1'b1;
                        end else begin
                            dout_data_q  <= bus.din_data;
                            dout_valid_q <= 1'b1;
`ifdef CHAN_PACKET_HEADER_EN
                            dout_sof_q   <= 1'b0;
`else
                            dout_sof_q   <= (wcnt_q == '0);
`endif
                            dout_eof_q   <= last_word;
                            wcnt_q       <= wcnt_q + 1'b1;
                            if (last_word) begin
                                pkt_count_q <= pkt_count_q + 16'd1;
                                gcnt_q      <= '0;
                                state_q     <= GAP;
                            end
                        end
                    end
                end

                GAP: begin
                    if (gcnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                        if (cfg_arm && !single_q) begin
                            state_q <= WAIT_SYNC;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        gcnt_q <= gcnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.dout_data  = dout_data_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_sof   = dout_sof_q;
    assign bus.dout_eof   = dout_eof_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.pkt_count  = pkt_count_q;
    assign bus.overflow   = overflow_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_chan_packet_ctrl.sv
// Bench for chan_packet_ctrl: randomized and directed stimulus checked
// every cycle against a packet-level reference model.
module tb_chan_packet_ctrl;
  localparam int DATA_W = 32;
  localparam int CHAN_W = 8;
  localparam int LEN_W  = 12;
  localparam int GAP    = 4;
`ifdef CHAN_PACKET_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif
  localparam int H = HDR_EN ? 1 : 0;

  // ---------------- clock / reset ----------------
  logic user_clk = 1'b0;
  logic user_rst = 1'b1;
  always #5 user_clk = ~user_clk;

  chan_packet_if #(.DATA_W(DATA_W), .CHAN_W(CHAN_W)) bus ();

  chan_packet_ctrl #(
    .DATA_W(DATA_W), .CHAN_W(CHAN_W), .LEN_W(LEN_W), .GAP_CYCLES(GAP)
  ) dut (
    .user_clk(user_clk),
    .user_rst(user_rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Packet-level view: "waiting" for a sync, a header "due", a packet in
  // flight with "sent" words, or "gap_left" idle cycles still to burn.
  logic        arm_prev, wait_sync, hdr_due, sending, sh_single;
  logic [7:0]  sh_chan;
  int          sh_len, sent, gap_left;
  logic        m_valid, m_busy, m_ovf;
  logic [15:0] m_count;
  logic [33:0] m_word;
  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];

  always @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      arm_prev = 0; wait_sync = 0; hdr_due = 0; sending = 0; sh_single = 0;
      sh_chan = 0; sh_len = 0; sent = 0; gap_left = 0;
      m_valid = 0; m_busy = 0; m_ovf = 0; m_count = 0; m_word = 0;
      exp_q.delete();
    end else begin
      logic arm, rise, matched, idle;
      arm     = bus.cfg_reg[31];
      rise    = arm && !arm_prev;
      matched = bus.din_valid && (bus.din_chan == sh_chan);
      idle    = !wait_sync && !hdr_due && !sending && (gap_left == 0);
      m_valid = 0;
      if (rise) m_ovf = 0;
      if (idle) begin
        if (rise && bus.cfg_reg[11:0] != 0) begin
          sh_chan   = bus.cfg_reg[23:16];
          sh_len    = int'(bus.cfg_reg[11:0]);
          sh_single = bus.cfg_reg[30];
          wait_sync = 1;
        end
      end else if (wait_sync) begin
        if (!arm) wait_sync = 0;
        else if (bus.sync_in) begin
          wait_sync = 0;
          sent = 0;
          if (HDR_EN) hdr_due = 1; else sending = 1;
        end
      end else if (hdr_due) begin
        if (matched) m_ovf = 1;
        if (bus.dout_ready) begin
          m_valid = 1;
          m_word  = {1'b1, 1'b0, sh_chan, 8'h00, m_count};
          exp_q.push_back(m_word);
          hdr_due = 0;
          sending = 1;
        end
      end else if (sending) begin
        if (matched) begin
          if (!bus.dout_ready) m_ovf = 1;
          else begin
            m_valid = 1;
            m_word  = {(!HDR_EN && sent == 0), (sent == sh_len - 1), bus.din_data};
            exp_q.push_back(m_word);
            sent++;
            if (sent == sh_len) begin
              sending  = 0;
              m_count  = m_count + 16'd1;
              gap_left = GAP;
            end
          end
        end
      end else begin
        gap_left--;
        if (gap_left == 0 && arm && !sh_single) wait_sync = 1;
      end
      m_busy   = wait_sync || hdr_due || sending || (gap_left > 0);
      arm_prev = arm;
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge user_clk) begin
    if (!user_rst) begin
      logic [33:0] e;
      e = '0;
      check("busy", 64'(bus.busy), 64'(m_busy));
      check("pkt_count", 64'(bus.pkt_count), 64'(m_count));
      check("overflow", 64'(bus.overflow), 64'(m_ovf));
      check("dout_valid", 64'(bus.dout_valid), 64'(m_valid));
      if (m_valid && exp_q.size() > 0) e = exp_q.pop_front();
      if (bus.dout_valid) begin
        got_q.push_back({bus.dout_sof, bus.dout_eof, bus.dout_data});
        if (m_valid) check("word", 64'({bus.dout_sof, bus.dout_eof, bus.dout_data}), 64'(e));
      end else begin
        check("idle_flags", 64'({bus.dout_sof, bus.dout_eof}), 64'(0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic v, input logic [7:0] c,
                       input logic [31:0] d, input logic r);
    @(negedge user_clk);
    bus.sync_in = s; bus.din_valid = v; bus.din_chan = c; bus.din_data = d; bus.dout_ready = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
  endtask

  // Channel 5 on every 4th cycle (i%4==1), channel 9 otherwise.
  task automatic stream(input int n, input int drop_at);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b1, (i % 4 == 1) ? 8'd5 : 8'd9, 32'hA000_0000 + 32'(i), (i != drop_at));
  endtask

  task automatic sync_pulse();
    drive(1'b1, 1'b0, 8'd0, 32'd0, 1'b1);
  endtask

  task automatic set_cfg(input logic [31:0] v);
    @(negedge user_clk);
    bus.cfg_reg = v;
  endtask

  task automatic rearm(input logic [31:0] v);
    set_cfg(32'h0); idle(1); set_cfg(v); idle(1);
  endtask

  task automatic do_reset();
    @(negedge user_clk);
    user_rst = 1'b1;
    bus.cfg_reg = 0; bus.sync_in = 0; bus.din_valid = 0; bus.din_chan = 0;
    bus.din_data = 0; bus.dout_ready = 1;
    idle(2);
    @(negedge user_clk);
    user_rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.cfg_reg = 0; bus.sync_in = 0; bus.din_valid = 0; bus.din_chan = 0;
    bus.din_data = 0; bus.dout_ready = 1;
    idle(3);
    check("rst_valid", 64'(bus.dout_valid), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_count", 64'(bus.pkt_count), 64'(0));
    check("rst_ovf", 64'(bus.overflow), 64'(0));
    check("rst_data", 64'(bus.dout_data), 64'(0));
    @(negedge user_clk);
    user_rst = 1'b0;

    // Continuous mode, len 4 on channel 5.
    set_cfg(32'h8005_0004); idle(2);
    check("armed_busy", 64'(bus.busy), 64'(1));
    got_q.delete(); sync_pulse(); stream(16, -1); idle(6);
    check("p1_size", 64'(got_q.size()), 64'(4 + H));
    check("p1_sof", 64'(got_q[0][33]), 64'(1));
    check("p1_first", 64'(got_q[H][31:0]), 64'h0000_0000_A000_0001);
    check("p1_eof", 64'(got_q[3 + H][32]), 64'(1));
    check("p1_last", 64'(got_q[3 + H][31:0]), 64'h0000_0000_A000_000D);
    check("p1_count", 64'(bus.pkt_count), 64'(1));
    got_q.delete(); sync_pulse(); stream(16, -1); idle(6);
    check("p2_size", 64'(got_q.size()), 64'(4 + H));
    check("p2_count", 64'(bus.pkt_count), 64'(2));

    // Single shot: second sync is ignored.
    rearm(32'hC005_0004);
    got_q.delete(); sync_pulse(); stream(16, -1); idle(6);
    check("ss_busy", 64'(bus.busy), 64'(0));
    sync_pulse(); stream(16, -1); idle(2);
    check("ss_size", 64'(got_q.size()), 64'(4 + H));
    check("ss_count", 64'(bus.pkt_count), 64'(3));

    // Drop one matched sample with ready low.
    rearm(32'h8005_0004);
    got_q.delete(); sync_pulse(); stream(20, 5); idle(6);
    check("ovf_set", 64'(bus.overflow), 64'(1));
    check("ovf_size", 64'(got_q.size()), 64'(4 + H));
    check("ovf_word2", 64'(got_q[H + 1][31:0]), 64'h0000_0000_A000_0009);
    rearm(32'h8005_0004);
    check("ovf_clear", 64'(bus.overflow), 64'(0));

    // Zero length arm is ignored; channel change mid-packet has no effect.
    rearm(32'h8005_0000); idle(3);
    check("len0_busy", 64'(bus.busy), 64'(0));
    rearm(32'h8005_0004);
    got_q.delete(); sync_pulse(); stream(8, -1);
    set_cfg(32'h8009_0004); stream(16, -1); idle(6);
    check("chg_size", 64'(got_q.size()), 64'(4 + H));
    check("chg_word3", 64'(got_q[H + 2][31:0]), 64'h0000_0000_A000_0001);

    // Arm cleared after the second word.
    rearm(32'h8005_0004);
    got_q.delete(); sync_pulse(); stream(8, -1);
    set_cfg(32'h0); stream(16, -1); idle(6);
    check("disarm_busy", 64'(bus.busy), 64'(0));
    check("disarm_size", 64'(got_q.size()), 64'(4 + H));
    check("disarm_eof", 64'(got_q[3 + H][32]), 64'(1));

    // Single word packets.
    rearm(32'h8005_0001);
    got_q.delete(); sync_pulse(); stream(4, -1); idle(6);
    check("len1_size", 64'(got_q.size()), 64'(1 + H));
    check("len1_sof", 64'(got_q[0][33]), 64'(1));
    check("len1_eof", 64'(got_q[H][32]), 64'(1));

    // Randomized traffic and control writes.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] c;
      int pick;
      @(negedge user_clk);
      if ($urandom_range(0, 59) == 0) begin
        c = '0;
        c[31] = ($urandom_range(0, 9) < 7);
        c[30] = ($urandom_range(0, 3) == 0);
        c[23:16] = ($urandom_range(0, 1) == 0) ? 8'd5 : 8'd9;
        c[11:0] = 12'($urandom_range(0, 5));
        bus.cfg_reg = c;
      end
      pick = int'($urandom_range(0, 2));
      bus.sync_in    = ($urandom_range(0, 19) == 0);
      bus.din_valid  = ($urandom_range(0, 1) == 0);
      bus.din_chan   = (pick == 0) ? 8'd5 : (pick == 1) ? 8'd9 : 8'($urandom_range(0, 255));
      bus.din_data   = $urandom;
      bus.dout_ready = ($urandom_range(0, 7) != 0);
    end

    // Asynchronous reset in the middle of a packet.
    do_reset();
    rearm(32'h8005_0004);
    sync_pulse(); stream(6, -1);
    @(posedge user_clk); #1;
    check("pre_rst_valid", 64'(bus.dout_valid), 64'(1));
    #1 user_rst = 1'b1;
    #1;
    check("arst_valid", 64'(bus.dout_valid), 64'(0));
    check("arst_busy", 64'(bus.busy), 64'(0));
    check("arst_eof", 64'(bus.dout_eof), 64'(0));
    check("arst_data", 64'(bus.dout_data), 64'(0));
    idle(2);
    bus.cfg_reg = 0;
    @(negedge user_clk);
    user_rst = 1'b0;

`ifdef CHAN_PACKET_HEADER_EN
    // Header word carries the channel and current packet count.
    for (int k = 0; k < 3; k++) begin
      rearm(32'hC005_0001); sync_pulse(); stream(4, -1); idle(6);
    end
    rearm(32'h8005_0002);
    got_q.delete(); sync_pulse(); stream(8, -1); idle(6);
    check("hdr_size", 64'(got_q.size()), 64'(3));
    check("hdr_word", 64'(got_q[0]), 64'({1'b1, 1'b0, 32'h0500_0003}));
    check("hdr_eof", 64'(got_q[2][32]), 64'(1));
`endif

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
